oled_pixel_streamer: RTL and testbench



---
 rtl/oled_pixel_streamer.sv | 177 +++++++++++++++++
 tb/tb_oled_pixel_streamer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_pixel_streamer.sv
// Raster-scans the panel, captures the colour returned for each coordinate and
// streams an address-window command followed by the frame's pixels over SPI mode 3.
module oled_pixel_streamer #(
   parameter int CLK_DIV    = 8,
   parameter int WIDTH      = 96,
   parameter int HEIGHT     = 64,
   parameter int GAP_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] pixel_data,
   output logic [6:0]  x,
   output logic [6:0]  y,
   output logic [12:0] pixel_index,
   output logic        cs_n,
   output logic        sclk,
   output logic        mosi,
   output logic        dc,
   output logic        frame_begin,
   output logic        busy
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [6:0]       X_LAST   = 7'(WIDTH - 1);
   localparam logic [6:0]       Y_LAST   = 7'(HEIGHT - 1);
   localparam logic [47:0]      CMD_SEQ  = {8'h15, 8'h00, 8'(WIDTH - 1),
                                            8'h75, 8'h00, 8'(HEIGHT - 1)};

   typedef enum logic [1:0] {IDLE, CMD, PIXELS, GAP} state_t;

   state_t           state, nxt_state;
   logic [DIV_W-1:0] div_cnt, nxt_div_cnt;
   logic [GAP_W-1:0] gap_cnt, nxt_gap_cnt;
   logic [5:0]       bit_cnt, nxt_bit_cnt;
   logic [14:0]      shreg, nxt_shreg;
   logic [6:0]       nxt_x, nxt_y, adv_x, adv_y;
   logic [12:0]      nxt_pixel_index, adv_index;
   logic             nxt_cs_n, nxt_sclk, nxt_mosi, nxt_dc, nxt_frame_begin, nxt_busy;
   logic             phase_end, start_frame, load_word, x_last, y_last;

   assign phase_end = (div_cnt == DIV_LAST);
   assign x_last    = (x == X_LAST);
   assign y_last    = (y == Y_LAST);
   assign adv_x     = x_last ? 7'd0 : x + 7'd1;
   assign adv_y     = x_last ? (y_last ? 7'd0 : y + 7'd1) : y;
   assign adv_index = (x_last && y_last) ? 13'd0 : pixel_index + 13'd1;

   always_comb begin
      nxt_state       = state;
      nxt_div_cnt     = div_cnt;
      nxt_gap_cnt     = gap_cnt;
      nxt_bit_cnt     = bit_cnt;
      nxt_shreg       = shreg;
      nxt_x           = x;
      nxt_y           = y;
      nxt_pixel_index = pixel_index;
      nxt_cs_n        = cs_n;
      nxt_sclk        = sclk;
      nxt_mosi        = mosi;
      nxt_dc          = dc;
      nxt_frame_begin = 1'b0;
      start_frame     = 1'b0;
      load_word       = 1'b0;

      case (state)
         IDLE: start_frame = enable;
         CMD, PIXELS: begin
            if (!phase_end) begin
               nxt_div_cnt = div_cnt + 1'b1;
            end else begin
               nxt_div_cnt = '0;
               if (!sclk) begin
                  nxt_sclk = 1'b1;
               end else if (bit_cnt != 6'd0) begin
                  nxt_sclk    = 1'b0;
                  nxt_bit_cnt = bit_cnt - 6'd1;
                  if (state == CMD) begin
                     nxt_mosi = CMD_SEQ[bit_cnt - 6'd1];
                  end else begin
                     nxt_mosi  = shreg[14];
                     nxt_shreg = {shreg[13:0], 1'b0};
                  end
               // pixel_index wraps to 0 only when the last pixel has been loaded
               end else if (state == CMD || pixel_index != 13'd0) begin
                  load_word = 1'b1;
               end else begin
                  nxt_state   = GAP;
                  nxt_gap_cnt = '0;
                  nxt_cs_n    = 1'b1;
                  nxt_sclk    = 1'b1;
                  nxt_dc      = 1'b0;
                  nxt_mosi    = 1'b0;
               end
            end
         end
         GAP: begin
            if (gap_cnt != GAP_LAST) begin
               nxt_gap_cnt = gap_cnt + 1'b1;
            end else if (enable) begin
               start_frame = 1'b1;
            end else begin
               nxt_state   = IDLE;
               nxt_gap_cnt = '0;
            end
         end
         default: nxt_state = IDLE;
      endcase

      if (start_frame) begin
         nxt_state       = CMD;
         nxt_cs_n        = 1'b0;
         nxt_dc          = 1'b0;
         nxt_sclk        = 1'b0;
         nxt_frame_begin = 1'b1;
         nxt_div_cnt     = '0;
         nxt_bit_cnt     = 6'd47;
         nxt_mosi        = CMD_SEQ[47];
         nxt_x           = 7'd0;
         nxt_y           = 7'd0;
         nxt_pixel_index = 13'd0;
      end

      // Capture this pixel's colour and move x/y on so the generator settles for a whole word
      if (load_word) begin
         nxt_state       = PIXELS;
         nxt_dc          = 1'b1;
         nxt_sclk        = 1'b0;
         nxt_bit_cnt     = 6'd15;
         nxt_mosi        = pixel_data[15];
         nxt_shreg       = pixel_data[14:0];
         nxt_x           = adv_x;
         nxt_y           = adv_y;
         nxt_pixel_index = adv_index;
      end

      nxt_busy = (nxt_state != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         div_cnt     <= '0;
         gap_cnt     <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         x           <= '0;
         y           <= '0;
         pixel_index <= '0;
         cs_n        <= 1'b1;
         sclk        <= 1'b1;
         mosi        <= 1'b0;
         dc          <= 1'b0;
         frame_begin <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= nxt_state;
         div_cnt     <= nxt_div_cnt;
         gap_cnt     <= nxt_gap_cnt;
         bit_cnt     <= nxt_bit_cnt;
         shreg       <= nxt_shreg;
         x           <= nxt_x;
         y           <= nxt_y;
         pixel_index <= nxt_pixel_index;
         cs_n        <= nxt_cs_n;
         sclk        <= nxt_sclk;
         mosi        <= nxt_mosi;
         dc          <= nxt_dc;
         frame_begin <= nxt_frame_begin;
         busy        <= nxt_busy;
      end
   end

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Scoreboard bench: frames of random colours are queued as expected SPI bytes/words
// and a monitor decodes the serial stream and raster counters independently.
module tb_oled_pixel_streamer;

   localparam int CLK_DIV = 3;
   localparam int W       = 12;
   localparam int H       = 5;
   localparam int GAP     = 7;
   localparam int N       = W * H;
   localparam int FR      = (48 + 16 * N) * 2 * CLK_DIV;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] pixel_data;
   logic [6:0]  x, y;
   logic [12:0] pixel_index;
   logic        cs_n, sclk, mosi, dc, frame_begin, busy;

   logic [15:0] mem [N];
   logic [16:0] exp_q [$];
   int          total = 0;
   int          bad = 0;
   int          exp_frames = 0;

   oled_pixel_streamer #(
      .CLK_DIV(CLK_DIV), .WIDTH(W), .HEIGHT(H), .GAP_CYCLES(GAP)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .pixel_data(pixel_data),
      .x(x), .y(y), .pixel_index(pixel_index), .cs_n(cs_n), .sclk(sclk),
      .mosi(mosi), .dc(dc), .frame_begin(frame_begin), .busy(busy)
   );

   always #5 clock = ~clock;

   always_comb begin
      pixel_data = 16'hDEAD;
      if (int'(x) < W && int'(y) < H) pixel_data = mem[int'(y) * W + int'(x)];
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask

   task automatic randomize_mem();
      for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
   endtask

   // Expected stream for one frame: address window command, then pixels in raster order
   task automatic push_frame();
      exp_q.push_back({1'b0, 8'h00, 8'h15});
      exp_q.push_back({1'b0, 8'h00, 8'h00});
      exp_q.push_back({1'b0, 8'h00, 8'(W - 1)});
      exp_q.push_back({1'b0, 8'h00, 8'h75});
      exp_q.push_back({1'b0, 8'h00, 8'h00});
      exp_q.push_back({1'b0, 8'h00, 8'(H - 1)});
      for (int i = 0; i < N; i++) exp_q.push_back({1'b1, mem[i]});
      exp_frames++;
   endtask

   task automatic wait_cs_rise(input string name, input int lim);
      logic ok;
      logic p;
      ok = 1'b0;
      p  = cs_n;
      for (int i = 0; i < lim && !ok; i++) begin
         @(negedge clock);
         if (cs_n && !p) ok = 1'b1;
         p = cs_n;
      end
      check(name, ok, 1);
   endtask

   task automatic wait_fb(input string name, input int lim);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(negedge clock);
         if (frame_begin) ok = 1'b1;
      end
      check(name, ok, 1);
   endtask

   task automatic wait_idx(input string name, input int val, input int lim);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(negedge clock);
         if (int'(pixel_index) == val) ok = 1'b1;
      end
      check(name, ok, 1);
   endtask

   task automatic wait_idle(input string name, input int lim);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(negedge clock);
         if (!busy) ok = 1'b1;
      end
      check(name, ok, 1);
   endtask

   // Monitor state
   logic [15:0] acc = '0;
   logic [16:0] e_word;
   logic        dc_first = 1'b0;
   logic        prev_sclk = 1'b1;
   logic        prev_cs_n = 1'b1;
   logic        gap_armed = 1'b0;
   logic        seen_last = 1'b0;
   logic        rst_seen = 1'b0;
   int          nb = 0;
   int          run = 0;
   int          low_run = 0;
   int          high_run = 0;
   int          fb_count = 0;
   int          prev_idx = 0;

   always @(negedge clock) begin
      if (rst_seen) begin
         acc = '0;
         nb  = 0;
      end

      if (!cs_n && sclk && !prev_sclk) begin
         if (nb == 0) dc_first = dc;
         acc = {acc[14:0], mosi};
         nb++;
         if (nb == (dc_first ? 16 : 8)) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", exp_q.size(), 1);
            end else begin
               e_word = exp_q.pop_front();
               if (dc_first) check("pixel_word", {dc_first, dc, acc}, {e_word[16], e_word[16], e_word[15:0]});
               else          check("cmd_byte",   {dc_first, dc, acc}, {e_word[16], e_word[16], e_word[15:0]});
            end
            acc = '0;
            nb  = 0;
         end
      end

      if (!cs_n) begin
         if (sclk != prev_sclk) begin
            if (!prev_cs_n) check("half_period", run, CLK_DIV);
            run = 1;
         end else begin
            run++;
         end
      end

      if (!cs_n) begin
         if (prev_cs_n) begin
            if (gap_armed) check("gap_len", high_run, GAP);
            gap_armed = 1'b0;
            low_run   = 0;
         end
         low_run++;
      end else begin
         if (!prev_cs_n) begin
            if (!rst_seen) begin
               check("cs_low_len", low_run, FR);
               check("last_pixel_seen", seen_last, 1);
            end
            gap_armed = !rst_seen;
            seen_last = 1'b0;
            high_run  = 0;
         end
         high_run++;
      end
      if (!busy) gap_armed = 1'b0;

      if (frame_begin) begin
         fb_count++;
         check("fb_align", {cs_n, prev_cs_n, dc}, 3'b010);
      end

      check("idx_vs_xy", pixel_index, int'(y) * W + int'(x));
      if (int'(pixel_index) != prev_idx && !rst_seen) begin
         check("idx_step", pixel_index, (prev_idx + 1) % N);
         check("xy_step", {x, y}, {7'((int'(pixel_index)) % W), 7'((int'(pixel_index)) / W)});
      end
      if (int'(x) == W - 1 && int'(y) == H - 1 && int'(pixel_index) == N - 1) seen_last = 1'b1;

      if (!cs_n || prev_cs_n) begin end
      if (cs_n && !prev_cs_n) rst_seen = 1'b0;
      prev_idx  = int'(pixel_index);
      prev_sclk = sclk;
      prev_cs_n = cs_n;
   end

   initial begin
      int d;
      randomize_mem();
      mem[0] = 16'h0000;
      mem[1] = 16'hF81F;

      repeat (3) @(negedge clock);
      check("reset_vals", {x, y, pixel_index, cs_n, sclk, mosi, dc, frame_begin, busy},
            {7'd0, 7'd0, 13'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      enable = 1'b1;
      @(negedge clock);
      check("reset_vals_enabled", {x, y, pixel_index, cs_n, sclk, mosi, dc, frame_begin, busy},
            {7'd0, 7'd0, 13'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

      // Frame 1: directed first two pixels
      push_frame();
      reset = 1'b0;
      @(negedge clock);
      check("fb_after_enable", {frame_begin, cs_n, busy}, 3'b101);
      wait_cs_rise("frame1_end", FR + 50);

      // Frame 2: new colours loaded during the gap, enable dropped mid-frame
      randomize_mem();
      push_frame();
      wait_fb("frame2_start", GAP + 10);
      d = $urandom_range(FR - 200, 100);
      repeat (d) @(negedge clock);
      enable = 1'b0;
      wait_cs_rise("frame2_end", FR + 50);
      repeat (GAP + 3) @(negedge clock);
      check("idle_after_gap", {busy, cs_n, sclk, frame_begin}, 4'b0110);
      repeat ($urandom_range(20, 5)) @(negedge clock);
      check("still_idle", {busy, cs_n}, 2'b01);

      // Frame 3: aborted by reset part way through the pixels
      randomize_mem();
      push_frame();
      enable = 1'b1;
      wait_idx("reach_pixel_30", 30, FR + 50);
      rst_seen = 1'b1;
      reset    = 1'b1;
      exp_q.delete();
      @(negedge clock);
      check("mid_reset_vals", {x, y, pixel_index, cs_n, sclk, mosi, dc, frame_begin, busy},
            {7'd0, 7'd0, 13'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

      // Frame 4: restart from the command sequence
      randomize_mem();
      push_frame();
      reset = 1'b0;
      wait_fb("frame4_start", 10);
      repeat (50) @(negedge clock);
      enable = 1'b0;
      wait_cs_rise("frame4_end", FR + 50);
      wait_idle("frame4_idle", GAP + 10);
      repeat (5) @(negedge clock);
      check("queue_drained", exp_q.size(), 0);
      check("frame_count", fb_count, exp_frames);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
